// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// HALT_OPCODE is also used by the control-unit decode, so it lives here.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    localparam logic [5:0] HALT_OPCODE    = 6'b111111;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Halt is decided on the opcode field alone; the low 26 bits are ignored.
    function automatic logic is_halt(input logic [31:0] word);
        return word[31:26] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian word assembler: shifts bytes in from the bottom so the first
// byte of a word ends up in [31:24] and the fourth in [7:0].
// word_out and full describe the word as it will stand after this cycle's
// shift, so the parent can capture a complete word on the accepting edge.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic        full,
    output logic [31:0] word_out
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]           word_q, word_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]           word_shift;

    // Each byte lane moves up one position on a shift; the new byte enters lane 0.
    assign word_shift[7:0] = byte_in;
    for (genvar gi = 1; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign word_shift[gi*8 +: 8] = word_q[(gi-1)*8 +: 8];
    end

    // Next shift-register contents and byte count
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = word_shift;
            cnt_d  = cnt_q + BYTE_CNT_W'(1);
        end
    end

    assign full     = shift_en && !clear && (cnt_q == LAST_BYTE);
    assign word_out = word_d;

    // Shift register and byte counter state
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: takes a byte stream over valid/ready, builds
// big-endian 32-bit words, writes them to consecutive word addresses from 0
// and holds the CPU until the halt instruction is stored or memory is full.
// Every output is a flop; output values are derived from the next state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              InsMemRW,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_overflow
);

    // Address of the final word slot; writing there without a halt is an overflow.
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] WORD_STEP      = ADDR_W'(BYTES_PER_WORD);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              rw_q, rw_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;

    logic              accept;
    logic              asm_clear;
    logic              asm_full;
    logic [31:0]       asm_word;

    // A byte transfers only while the registered ready is high (RECV only).
    assign accept = byte_valid && ready_q;

    word_assembler u_word_assembler (
        .CLK      (CLK),
        .Reset    (Reset),
        .shift_en (accept),
        .clear    (asm_clear),
        .byte_in  (byte_data),
        .full     (asm_full),
        .word_out (asm_word)
    );

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus address, write data and overflow bookkeeping
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ovf_d     = ovf_q;
        asm_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RECV;
                    addr_d    = '0;
                    ovf_d     = 1'b0;
                    asm_clear = 1'b1;
                end
            end
            ST_RECV: begin
                // start is deliberately ignored while receiving
                if (asm_full) begin
                    state_d = ST_WRITE;
                    wdata_d = asm_word;
                end
            end
            ST_WRITE: begin
                if (is_halt(wdata_q)) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b0;
                end else if (addr_q == LAST_WORD_ADDR) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b1;
                end else begin
                    state_d   = ST_RECV;
                    addr_d    = addr_q + WORD_STEP;
                    asm_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming state, registered below
    always_comb begin
        ready_d = (state_d == ST_RECV);
        rw_d    = (state_d == ST_RECV) || (state_d == ST_WRITE);
        we_d    = (state_d == ST_WRITE);
        hold_d  = (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            rw_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            rw_q    <= rw_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign byte_ready   = ready_q;
    assign InsMemRW     = rw_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err_overflow = ovf_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The control unit only ever reads instruction memory (InsMemRW=0); this block is the writer.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions, writes them to consecutive word addresses from 0, and holds the CPU until loading completes.
- Loading stops after the halt instruction (opcode 6'b111111) is written, or on address overflow.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory. Capacity is 2^ADDR_W bytes, i.e. 2^(ADDR_W-2) words.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse that begins a load; sampled only in IDLE or DONE.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- InsMemRW  out  1  1 = instruction memory in write mode (RECV/WRITE), 0 = read mode.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  byte address of the write; always a multiple of 4.
- imem_wdata  out  32  assembled instruction.
- cpu_hold  out  1  1 = CPU held (forces PCWre low externally).
- done  out  1  load finished.
- err_overflow  out  1  memory filled before halt was seen.

Behaviour:
- Reset (async, Reset=0) sets: state IDLE, byte_ready 0, InsMemRW 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, done 0, err_overflow 0, byte count 0.
  - Reset mid-load discards any partial word; no write is issued.
- All outputs are registered; byte_ready depends only on state.
- IDLE:
  - cpu_hold=1.
  - start=1 -> RECV; clears imem_addr, byte count, done, err_overflow.
- RECV:
  - byte_ready=1, InsMemRW=1.
  - Each accepted byte shifts into the word: the 1st byte lands in [31:24], the 4th in [7:0].
  - When the 4th byte is accepted, the next state is WRITE.
  - start is ignored.
  - byte_valid gaps simply stall; bytes are never dropped.
- WRITE (exactly one cycle):
  - imem_we=1, byte_ready=0, imem_wdata = assembled word, imem_addr = current word address.
  - Latency: 4th byte accepted at edge N -> imem_we high in the cycle after edge N.
  - Next state:
    - if wdata[31:26]==6'b111111 -> DONE, err_overflow=0;
    - else if imem_addr == 2^ADDR_W-4 -> DONE, err_overflow=1;
    - else imem_addr += 4 (no wrap) -> RECV, byte count 0.
- DONE:
  - done=1, cpu_hold=0, InsMemRW=0, byte_ready=0, imem_we=0.
  - imem_addr holds the last written address.
  - start=1 -> RECV with the same clearing as from IDLE; done drops on that edge.
- Halt detection uses the opcode bits only; the lower 26 bits are don't-care.
- The halt word itself is always written to memory.
- Simultaneous byte_valid and start in IDLE/DONE: no byte is accepted that cycle (byte_ready=0).

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RECV, WRITE, DONE);
  - HALT_OPCODE = 6'b111111;
  - BYTES_PER_WORD = 4.
  - HALT_OPCODE is shared with the control-unit decode.
- One sub-module: word_assembler.
  - 32-bit shift register plus 2-bit byte counter.
  - Ports: shift enable, clear, full flag, word out.
  - Clocked by CLK, reset by Reset.
- FSM and address counter stay in imem_loader.

Test Plan:
- Halt terminates the load: stream bytes of 0x00221800, 0x08010005, 0xFC000000 ->
  - imem_we pulses at addr 0/4/8 with those exact words;
  - done=1 and cpu_hold=0 the cycle after the third write;
  - err_overflow=0.
- Backpressure: insert random 1-5 cycle byte_valid gaps; hold byte_valid high during WRITE ->
  - byte_ready=0 in WRITE;
  - the held byte is accepted the next cycle;
  - written words are bit-exact.
- Overflow: ADDR_W=4, send 4 words 0x00000000..0x00000003 with no halt ->
  - writes at 0,4,8,12;
  - then done=1, err_overflow=1;
  - no 5th write.
- Reset mid-load: assert Reset after 2 bytes of a word ->
  - all outputs at reset values immediately (async);
  - a new start plus a full word writes to addr 0 with only the new bytes.
- start handling:
  - start pulsed during RECV -> no effect (address continues).
  - start in DONE -> done=0, err_overflow=0, next write at addr 0.
- Halt decode boundary:
  - word 0xFC00FFFF -> terminates.
  - word 0xF8000000 (opcode 6'b111110) -> written, load continues at next address.
